// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential unsigned divider.
// Holds the FSM state type, the operation class recorded at accept time,
// the default width, its log2, and the all-ones quotient used for divide by zero.
package seq_div_pkg;

   localparam int unsigned WIDTH_DEFAULT = 16;
   localparam int unsigned LOG2_WIDTH    = $clog2(WIDTH_DEFAULT);

   // Widest legal operand; narrower builds slice the low bits of DIV0_QUOTIENT.
   localparam int unsigned WIDTH_MAX     = 32;
   localparam logic [WIDTH_MAX-1:0] DIV0_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE,
      ITER,
      DONE
   } state_e;

   // How the operation was resolved, so that DONE knows which result to write.
   typedef enum logic [1:0] {
      OP_GENERAL,
      OP_ZERO,
      OP_POW2,
      OP_EARLY
   } op_kind_e;

endpackage

// File: rtl/seq_divider16_pow2_detect.sv
// Divisor classifier: flags zero and single-bit divisors and encodes the
// position of the set bit. This is the inverse of the downstream
// shift-amount decoder. idx_o is only meaningful when is_pow2_o is high.
module pow2_detect
   import seq_div_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT,
   parameter int unsigned NW    = $clog2(WIDTH)
)
(
   input  logic [WIDTH-1:0] d_i,
   output logic             is_zero_o,
   output logic             is_pow2_o,
   output logic [NW-1:0]    idx_o
);

   // Mask of all bit positions whose binary index has bit b set.
   function automatic logic [WIDTH-1:0] index_mask(input int b);
      logic [WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         m[i] = ((i >> b) & 1) != 0;
      end
      return m;
   endfunction

   // For a one-hot input, OR-ing the masked bits yields each index bit directly.
   generate
      for (genvar gi = 0; gi < int'(NW); gi++) begin : g_idx
         localparam logic [WIDTH-1:0] MASK = index_mask(gi);
         assign idx_o[gi] = |(d_i & MASK);
      end
   endgenerate

   assign is_zero_o = (d_i == '0);
   // Clearing the lowest set bit leaves zero only for a single-bit value.
   assign is_pow2_o = !is_zero_o && ((d_i & (d_i - WIDTH'(1))) == '0);

endmodule

// File: rtl/seq_divider16.sv
// Multi-cycle unsigned divider with zero and power-of-two fast paths.
// General divisors use a restoring division, one quotient bit per cycle.
// Optional build macro: SEQ_DIV_EARLY_TERM_EN - when defined, a general
// divisor larger than the dividend resolves in one cycle (same results).
module seq_divider16
   import seq_div_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             pow2_hit
);

   localparam int unsigned      NW        = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] DIV0_Q    = DIV0_QUOTIENT[WIDTH-1:0];
   localparam logic [NW-1:0]    LAST_ITER = NW'(WIDTH - 1);

   state_e           state_q, state_d;
   op_kind_e         kind_q,  kind_d;
   logic [WIDTH-1:0] a_q,     a_d;      // dividend, becomes the quotient while iterating
   logic [WIDTH-1:0] dv_q,    dv_d;     // latched divisor
   logic [WIDTH-1:0] p_q,     p_d;      // partial remainder
   logic [NW-1:0]    cnt_q,   cnt_d;
   logic [NW-1:0]    n_q,     n_d;      // shift amount for the power-of-two path
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic [WIDTH-1:0] quot_q,  quot_d;
   logic [WIDTH-1:0] rem_q,   rem_d;
   logic             dbz_q,   dbz_d;
   logic             p2_q,    p2_d;

   logic             det_zero;
   logic             det_pow2;
   logic [NW-1:0]    det_idx;
   logic             early_hit;
   logic             accept;
   logic [WIDTH:0]   p_shift;
   logic [WIDTH:0]   p_diff;
   logic             q_bit;

   pow2_detect #(
      .WIDTH (WIDTH),
      .NW    (NW)
   ) u_pow2_detect (
      .d_i       (divisor),
      .is_zero_o (det_zero),
      .is_pow2_o (det_pow2),
      .idx_o     (det_idx)
   );

`ifdef SEQ_DIV_EARLY_TERM_EN
   assign early_hit = (dividend < divisor);
`else
   assign early_hit = 1'b0;
`endif

   // A start in the cycle done pulses is dropped; the next accept is one cycle later.
   assign accept = start && !done_q;

   // One restoring step on WIDTH+1 bits so the shifted-out bit is kept.
   assign p_shift = {p_q, a_q[WIDTH-1]};
   assign p_diff  = p_shift - {1'b0, dv_q};
   // No borrow out of the subtraction means P' >= d.
   assign q_bit   = ~p_diff[WIDTH];

   // Next-state and datapath update; every target holds unless assigned below.
   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      a_d     = a_q;
      dv_d    = dv_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      n_d     = n_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      p2_d    = p2_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d    = dividend;
               dv_d   = divisor;
               n_d    = det_idx;
               p_d    = '0;
               cnt_d  = '0;
               busy_d = 1'b1;
               if (det_zero) begin
                  kind_d  = OP_ZERO;
                  state_d = DONE;
               end else if (det_pow2) begin
                  kind_d  = OP_POW2;
                  state_d = DONE;
               end else if (early_hit) begin
                  kind_d  = OP_EARLY;
                  state_d = DONE;
               end else begin
                  kind_d  = OP_GENERAL;
                  state_d = ITER;
               end
            end
         end

         ITER: begin
            p_d   = q_bit ? p_diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
            a_d   = {a_q[WIDTH-2:0], q_bit};
            cnt_d = cnt_q + NW'(1);
            if (cnt_q == LAST_ITER) begin
               state_d = DONE;
            end
         end

         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
            dbz_d   = 1'b0;
            p2_d    = 1'b0;
            case (kind_q)
               OP_ZERO: begin
                  quot_d = DIV0_Q;
                  rem_d  = a_q;
                  dbz_d  = 1'b1;
               end
               OP_POW2: begin
                  quot_d = a_q >> n_q;
                  rem_d  = a_q & ~(DIV0_Q << n_q);
                  p2_d   = 1'b1;
               end
               OP_EARLY: begin
                  quot_d = '0;
                  rem_d  = a_q;
               end
               default: begin
                  quot_d = a_q;
                  rem_d  = p_q;
               end
            endcase
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset clears everything and aborts any operation.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         kind_q  <= OP_GENERAL;
         a_q     <= '0;
         dv_q    <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
         n_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         p2_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         a_q     <= a_d;
         dv_q    <= dv_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         p2_q    <= p2_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign pow2_hit    = p2_q;

endmodule
